// File: rtl/router_fsm.sv
// Packet router control FSM: decodes the header address, sequences the write
// enables for the payload and parity bytes, and handles full and timeout conditions.
module router_fsm (
   input  logic       clock,
   input  logic       reset,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       full_state,
   output logic       laf_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] addr_reg;
   logic       empty_in_sel;
   logic       empty_latched_sel;
   logic       soft_reset_sel;
   logic [7:0] outs_next;

   // Empty flag of the port named by the incoming header.
   always_comb begin
      empty_in_sel = 1'b0;
      case (data_in)
         2'd0:    empty_in_sel = fifo_empty_0;
         2'd1:    empty_in_sel = fifo_empty_1;
         2'd2:    empty_in_sel = fifo_empty_2;
         default: empty_in_sel = 1'b0;
      endcase
   end

   // Empty flag and timeout of the port owning the current packet.
   always_comb begin
      empty_latched_sel = 1'b0;
      soft_reset_sel    = 1'b0;
      case (addr_reg)
         2'd0: begin
            empty_latched_sel = fifo_empty_0;
            soft_reset_sel    = soft_reset_0;
         end
         2'd1: begin
            empty_latched_sel = fifo_empty_1;
            soft_reset_sel    = soft_reset_1;
         end
         2'd2: begin
            empty_latched_sel = fifo_empty_2;
            soft_reset_sel    = soft_reset_2;
         end
         default: begin
            empty_latched_sel = 1'b0;
            soft_reset_sel    = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         DECODE_ADDRESS: begin
            // Address 3 has no port: the header is dropped without leaving this state.
            if (pkt_valid && data_in != 2'd3)
               state_next = empty_in_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         WAIT_TILL_EMPTY: begin
            if (empty_latched_sel)
               state_next = LOAD_FIRST_DATA;
         end
         LOAD_FIRST_DATA: state_next = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)
               state_next = FIFO_FULL_STATE;
            else if (!pkt_valid)
               state_next = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full)
               state_next = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)
               state_next = DECODE_ADDRESS;
            else if (low_pkt_valid)
               state_next = LOAD_PARITY;
            else
               state_next = LOAD_DATA;
         end
         LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         default: state_next = DECODE_ADDRESS;
      endcase
      // A read timeout on the owning port aborts the packet from any loading state.
      if (state_reg != DECODE_ADDRESS && soft_reset_sel)
         state_next = DECODE_ADDRESS;
   end

   // Outputs are registered from the next-state decode so they track the state register exactly.
   // Bit order: detect_add, lfd, ld, full, laf, write_enb, rst_int, busy.
   always_comb begin
      outs_next = 8'b1000_0000;
      case (state_next)
         DECODE_ADDRESS:     outs_next = 8'b1000_0000;
         LOAD_FIRST_DATA:    outs_next = 8'b0100_0001;
         LOAD_DATA:          outs_next = 8'b0010_0100;
         FIFO_FULL_STATE:    outs_next = 8'b0001_0001;
         LOAD_AFTER_FULL:    outs_next = 8'b0000_1101;
         LOAD_PARITY:        outs_next = 8'b0000_0101;
         CHECK_PARITY_ERROR: outs_next = 8'b0000_0011;
         WAIT_TILL_EMPTY:    outs_next = 8'b0000_0001;
         default:            outs_next = 8'b1000_0000;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= DECODE_ADDRESS;
         addr_reg      <= 2'd0;
         detect_add    <= 1'b1;
         lfd_state     <= 1'b0;
         ld_state      <= 1'b0;
         full_state    <= 1'b0;
         laf_state     <= 1'b0;
         write_enb_reg <= 1'b0;
         rst_int_reg   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == DECODE_ADDRESS && state_next != DECODE_ADDRESS)
            addr_reg <= data_in;
         {detect_add, lfd_state, ld_state, full_state,
          laf_state, write_enb_reg, rst_int_reg, busy} <= outs_next;
      end
   end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks the packet, wait, full, timeout and reset
// paths and compares the Moore output vector against hand-derived state codes.
module tb_router_fsm;

   logic       clock = 1'b0;
   logic       reset;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       detect_add, lfd_state, ld_state, full_state, laf_state;
   logic       write_enb_reg, rst_int_reg, busy;

   int checks   = 0;
   int failures = 0;
   int we_count;

   // Output vector: detect_add, lfd, ld, full, laf, write_enb, rst_int, busy
   localparam logic [7:0] DA  = 8'b1000_0000;
   localparam logic [7:0] LFD = 8'b0100_0001;
   localparam logic [7:0] LD  = 8'b0010_0100;
   localparam logic [7:0] FUL = 8'b0001_0001;
   localparam logic [7:0] LAF = 8'b0000_1101;
   localparam logic [7:0] LP  = 8'b0000_0101;
   localparam logic [7:0] CPE = 8'b0000_0011;
   localparam logic [7:0] WTE = 8'b0000_0001;

   always #5 clock = ~clock;

   router_fsm dut (
      .clock         (clock),
      .reset         (reset),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .full_state    (full_state),
      .laf_state     (laf_state),
      .write_enb_reg (write_enb_reg),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy)
   );

   wire [7:0] outs = {detect_add, lfd_state, ld_state, full_state,
                      laf_state, write_enb_reg, rst_int_reg, busy};

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end else begin
         $display("ok   %s: %0h", tag, actual);
      end
   endtask

   // One clock edge, then compare outputs on the falling edge.
   task automatic step(input string tag, input logic [7:0] expected);
      @(posedge clock);
      @(negedge clock);
      if (write_enb_reg) we_count++;
      check_eq(tag, {24'd0, outs}, {24'd0, expected});
   endtask

   initial begin
      reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
      we_count = 0;
      step("reset_state", DA);
      reset = 1'b0;
      step("idle_hold", DA);

      // Normal packet to port 1
      we_count = 0;
      pkt_valid = 1'b1; data_in = 2'd1;
      step("p1_lfd", LFD);
      step("p1_ld1", LD);
      step("p1_ld2", LD);
      step("p1_ld3", LD);
      pkt_valid = 1'b0;
      step("p1_lp", LP);
      step("p1_cpe", CPE);
      step("p1_da", DA);
      check_eq("p1_we_cycles", we_count, 4);

      // Port 2 busy: wait until empty, then full during LD
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      step("p2_wte", WTE);
      step("p2_wte_hold", WTE);
      fifo_empty_2 = 1'b1;
      step("p2_lfd", LFD);
      soft_reset_1 = 1'b1;
      step("p2_ld_sr1_ignored", LD);
      soft_reset_1 = 1'b0; fifo_full = 1'b1;
      step("p2_full", FUL);
      step("p2_full_hold", FUL);
      fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
      step("p2_laf", LAF);
      step("p2_lp", LP);
      low_pkt_valid = 1'b0;
      step("p2_cpe", CPE);
      step("p2_da", DA);

      // Port 0 waiting, soft reset on other port ignored, own port aborts
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
      step("p0_wte", WTE);
      soft_reset_1 = 1'b1;
      step("p0_sr1_ignored", WTE);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1; pkt_valid = 1'b0;
      step("p0_sr0_abort", DA);
      soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;

      // Address 3 is dropped
      pkt_valid = 1'b1; data_in = 2'd3;
      step("addr3_drop1", DA);
      step("addr3_drop2", DA);

      // LAF back to LD, CPE with full goes to FULL, reset in FULL
      data_in = 2'd1;
      step("p1b_lfd", LFD);
      step("p1b_ld", LD);
      fifo_full = 1'b1;
      step("p1b_full", FUL);
      fifo_full = 1'b0;
      step("p1b_laf", LAF);
      step("p1b_laf_to_ld", LD);
      pkt_valid = 1'b0;
      step("p1b_lp", LP);
      fifo_full = 1'b1;
      step("p1b_cpe", CPE);
      step("p1b_cpe_to_full", FUL);
      reset = 1'b1;
      step("reset_in_full", DA);
      reset = 1'b0; fifo_full = 1'b0;
      step("post_reset_idle", DA);

      // Port 0: LAF with parity_done returns to DA; then soft reset aborts LD
      pkt_valid = 1'b1; data_in = 2'd0;
      step("p0b_lfd", LFD);
      step("p0b_ld", LD);
      fifo_full = 1'b1;
      step("p0b_full", FUL);
      fifo_full = 1'b0; parity_done = 1'b1;
      step("p0b_laf", LAF);
      pkt_valid = 1'b0;
      step("p0b_laf_done", DA);
      parity_done = 1'b0; pkt_valid = 1'b1;
      step("p0c_lfd", LFD);
      step("p0c_ld", LD);
      soft_reset_0 = 1'b1; pkt_valid = 1'b0;
      step("p0c_sr0_abort", DA);
      soft_reset_0 = 1'b0;
      step("p0c_idle", DA);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have no parameters; the router has 3 output ports and 2-bit addressing, both fixed.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising clock edge.
REQ-004 pkt_valid  input  1  high while the source drives header or payload bytes; falls on the parity byte.
REQ-005 data_in  input  2  header address bits, valid while detect_add is high.
REQ-006 fifo_full  input  1  full flag of the currently addressed FIFO.
REQ-007 fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  empty flags of the output FIFOs.
REQ-008 soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  read-timeout resets, one per output FIFO.
REQ-009 parity_done  input  1  parity byte has been written into the register stage.
REQ-010 low_pkt_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-011 detect_add, lfd_state, ld_state, full_state, laf_state  output  1 each  one-hot state indicators.
REQ-012 write_enb_reg  output  1  write strobe to the write-enable decoder.
REQ-013 rst_int_reg  output  1  clears the internal parity-error logic.
REQ-014 busy  output  1  source must hold data_in stable while high.

Function
REQ-015 The FSM SHALL have 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-016 In DECODE_ADDRESS with pkt_valid=1, data_in=N (0..2) and fifo_empty_N=1, next state SHALL be LOAD_FIRST_DATA.
REQ-017 In DECODE_ADDRESS with pkt_valid=1, data_in=N (0..2) and fifo_empty_N=0, next state SHALL be WAIT_TILL_EMPTY.
REQ-018 In DECODE_ADDRESS with data_in=3 or pkt_valid=0, the FSM SHALL stay; address 3 is dropped silently.
REQ-019 The address SHALL be latched into a 2-bit register on the DECODE_ADDRESS exit edge and held until the next DECODE_ADDRESS exit.
REQ-020 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when fifo_empty of the latched address is 1; otherwise it stays.
REQ-021 LOAD_FIRST_DATA SHALL go to LOAD_DATA unconditionally, so it lasts exactly 1 cycle.
REQ-022 LOAD_DATA transitions: fifo_full=1 -> FIFO_FULL_STATE (highest priority); else pkt_valid=0 -> LOAD_PARITY; else stay.
REQ-023 FIFO_FULL_STATE SHALL go to LOAD_AFTER_FULL when fifo_full=0; otherwise it stays.
REQ-024 LOAD_AFTER_FULL transitions: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
REQ-025 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR unconditionally.
REQ-026 CHECK_PARITY_ERROR transitions: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-027 In any state other than DECODE_ADDRESS, soft_reset_N=1 for the latched N SHALL force next state DECODE_ADDRESS, overriding REQ-020..026.
REQ-028 soft_reset for a non-latched port SHALL be ignored.
REQ-029 Outputs SHALL be Moore, decoded from the current state only, with zero added latency.
REQ-030 Each indicator SHALL be high only in its state: detect_add in DECODE_ADDRESS, lfd_state in LOAD_FIRST_DATA, ld_state in LOAD_DATA, full_state in FIFO_FULL_STATE, laf_state in LOAD_AFTER_FULL.
REQ-031 write_enb_reg SHALL be high in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL only.
REQ-032 rst_int_reg SHALL be high in CHECK_PARITY_ERROR only.
REQ-033 busy SHALL be high in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-034 Unused state encodings SHALL return to DECODE_ADDRESS on the next edge.

Reset
REQ-035 reset=1 at a clock edge SHALL put the FSM in DECODE_ADDRESS and clear the latched address to 0, with priority over soft_reset and all transitions.
REQ-036 After reset: detect_add=1; lfd_state, ld_state, full_state, laf_state, write_enb_reg, rst_int_reg and busy = 0.
REQ-037 Reset asserted mid-packet (any state) SHALL give the REQ-036 outputs on the next edge.

Verification
REQ-038 Empty FIFO 1, data_in=1, pkt_valid high 4 cycles then low -> state sequence DA, LFD, LD x3, LP, CPE, DA; write_enb_reg high 4 cycles total.
REQ-039 fifo_empty_2=0, header data_in=2 -> WAIT_TILL_EMPTY with busy=1 until fifo_empty_2 rises, then LFD on the next edge.
REQ-040 fifo_full=1 during LD -> FIFO_FULL_STATE with write_enb_reg=0; release with parity_done=0, low_pkt_valid=1 -> LAF, then LP, CPE.
REQ-041 Latched address 0 in WAIT_TILL_EMPTY: soft_reset_1=1 -> no effect; soft_reset_0=1 -> DECODE_ADDRESS next edge.
REQ-042 data_in=3 with pkt_valid=1 -> FSM stays in DECODE_ADDRESS and write_enb_reg stays 0.
REQ-043 reset=1 asserted in FIFO_FULL_STATE -> next edge detect_add=1, busy=0, latched address 0.
